// File: rtl/gate_check_pkg.sv
// Shared types and constants for the 2-input gate truth-table checker.
// Truth tables are indexed by {in1,in0}; bit k is the expected out for vector k.
package gate_check_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int NUM_VECTORS = 4;

   localparam logic [3:0] NAND_TT = 4'b0111;
   localparam logic [3:0] AND_TT  = 4'b1000;
   localparam logic [3:0] OR_TT   = 4'b1110;
   localparam logic [3:0] NOR_TT  = 4'b0001;
   localparam logic [3:0] XOR_TT  = 4'b0110;

   // Case-inequality so an undriven or unknown gate output counts as a mismatch.
   function automatic logic vec_mismatch(input logic sampled, input logic expected);
      return (sampled !== expected);
   endfunction

endpackage

// File: rtl/gate_truth_table_checker_if.sv
// Control/status and gate-pin bundle between the checker and its environment.
// The slave side is the checker; the master side drives start and the gate output.
interface gate_truth_table_checker_if;
   import gate_check_pkg::*;

   logic                   start;
   logic                   in0;
   logic                   in1;
   logic                   out;
   logic                   busy;
   logic                   done;
   logic                   pass;
   logic [NUM_VECTORS-1:0] fail_mask;

   modport master (
      output start,
      output out,
      input  in0,
      input  in1,
      input  busy,
      input  done,
      input  pass,
      input  fail_mask
   );

   modport slave (
      input  start,
      input  out,
      output in0,
      output in1,
      output busy,
      output done,
      output pass,
      output fail_mask
   );

endinterface

// File: rtl/settle_timer.sv
// Loadable down-counter that measures how long each vector is held before sampling.
// Counts down only while enabled and stops at zero.
module settle_timer #(
   parameter int SETTLE = 1,
   localparam int TW    = (SETTLE > 1) ? $clog2(SETTLE) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          en,
   input  logic [TW-1:0] load_val,
   output logic [TW-1:0] value,
   output logic          zero
);

   logic [TW-1:0] value_q;
   logic [TW-1:0] value_d;

   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = load_val;
      end else if (en && (value_q != {TW{1'b0}})) begin
         value_d = value_q - {{(TW-1){1'b0}}, 1'b1};
      end else begin
         value_d = value_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q <= {TW{1'b0}};
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;
   assign zero  = (value_q == {TW{1'b0}});

endmodule

// File: rtl/gate_truth_table_checker.sv
// Stimulus-and-check engine: sweeps a 2-input gate through {in1,in0}=00..11,
// samples its output after SETTLE cycles per vector and reports a failure mask.
module gate_truth_table_checker
   import gate_check_pkg::*;
#(
   parameter logic [3:0] EXPECTED = NAND_TT,
   parameter int         SETTLE   = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   gate_truth_table_checker_if.slave   bus
);

   localparam int            TW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [TW-1:0] RELOAD = TW'(SETTLE - 1);

   if (SETTLE < 1) begin : g_settle_check
      $error("gate_truth_table_checker: SETTLE must be >= 1");
   end

   state_e                 state_q, state_d;
   logic [1:0]             idx_q, idx_d;
   logic                   in0_q, in0_d;
   logic                   in1_q, in1_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   pass_q, pass_d;
   logic [NUM_VECTORS-1:0] fail_mask_q, fail_mask_d;

   logic                   tmr_load_s;
   logic                   tmr_en_s;
   logic                   tmr_zero_s;
   logic [TW-1:0]          tmr_value_s;
   logic                   mismatch_s;
   logic [NUM_VECTORS-1:0] mask_upd_s;

   settle_timer #(
      .SETTLE (SETTLE)
   ) u_settle_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load_s),
      .en       (tmr_en_s),
      .load_val (RELOAD),
      .value    (tmr_value_s),
      .zero     (tmr_zero_s)
   );

   // The mask seen at the final sample already includes the vector being compared.
   always_comb begin
      mismatch_s          = vec_mismatch(bus.out, EXPECTED[idx_q]);
      mask_upd_s          = fail_mask_q;
      mask_upd_s[idx_q]   = fail_mask_q[idx_q] | mismatch_s;
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      in0_d       = in0_q;
      in1_d       = in1_q;
      busy_d      = busy_q;
      done_d      = done_q;
      pass_d      = pass_q;
      fail_mask_d = fail_mask_q;
      tmr_load_s  = 1'b0;
      tmr_en_s    = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               fail_mask_d = {NUM_VECTORS{1'b0}};
               done_d      = 1'b0;
               pass_d      = 1'b0;
               busy_d      = 1'b1;
               idx_d       = 2'd0;
               in0_d       = 1'b0;
               in1_d       = 1'b0;
               tmr_load_s  = 1'b1;
               state_d     = RUN;
            end else begin
               state_d     = state_q;
            end
         end
         RUN: begin
            if (!tmr_zero_s) begin
               tmr_en_s = 1'b1;
            end else begin
               fail_mask_d = mask_upd_s;
               if (idx_q != 2'd3) begin
                  idx_d          = idx_q + 2'd1;
                  {in1_d, in0_d} = idx_q + 2'd1;
                  tmr_load_s     = 1'b1;
               end else begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (mask_upd_s == {NUM_VECTORS{1'b0}});
                  in0_d   = 1'b0;
                  in1_d   = 1'b0;
                  state_d = DONE;
               end
            end
         end
         default: begin
            state_d     = IDLE;
            idx_d       = 2'd0;
            in0_d       = 1'b0;
            in1_d       = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            fail_mask_d = {NUM_VECTORS{1'b0}};
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= 2'd0;
         in0_q       <= 1'b0;
         in1_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_mask_q <= {NUM_VECTORS{1'b0}};
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         in0_q       <= in0_d;
         in1_q       <= in1_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         fail_mask_q <= fail_mask_d;
      end
   end

   assign bus.in0       = in0_q;
   assign bus.in1       = in1_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench for gate_truth_table_checker: two instances (SETTLE=1 and SETTLE=3)
// each wired to a behavioural gate model, with a scoreboard of expected sweep results.
module tb_gate_truth_table_checker;
   import gate_check_pkg::*;

   typedef enum int {G_NAND, G_AND, G_OR, G_NOR, G_XOR} gate_e;

   typedef struct {
      int         sel;
      gate_e      gate;
      int         xvec;
      logic [3:0] exp_mask;
      logic       exp_pass;
   } vec_t;

   typedef struct {
      logic [3:0] mask;
      logic       pass;
   } exp_t;

   logic  clk;
   logic  rst;
   int    checks;
   int    errors;
   exp_t  sb_q[$];
   gate_e gate_a, gate_b;
   int    xvec_a, xvec_b;
   vec_t  vecs[7];

   gate_truth_table_checker_if ifa ();
   gate_truth_table_checker_if ifb ();

   gate_truth_table_checker #(.EXPECTED(NAND_TT), .SETTLE(1)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa.slave)
   );

   gate_truth_table_checker #(.EXPECTED(NAND_TT), .SETTLE(3)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic gate_out(input gate_e g, input logic a, input logic b, input int xv);
      logic r;
      case (g)
         G_NAND:  r = ~(a & b);
         G_AND:   r = a & b;
         G_OR:    r = a | b;
         G_NOR:   r = ~(a | b);
         G_XOR:   r = a ^ b;
         default: r = 1'b0;
      endcase
      if (int'({b, a}) == xv) r = 1'bx;
      return r;
   endfunction

   always_comb ifa.out = gate_out(gate_a, ifa.in0, ifa.in1, xvec_a);
   always_comb ifb.out = gate_out(gate_b, ifb.in0, ifb.in1, xvec_b);

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int settle_of(input int sel);
      return (sel == 0) ? 1 : 3;
   endfunction

   // Packed observation {busy, done, pass, in1, in0, fail_mask[3:0]}.
   function automatic logic [8:0] obs(input int sel);
      if (sel == 0) return {ifa.busy, ifa.done, ifa.pass, ifa.in1, ifa.in0, ifa.fail_mask};
      return {ifb.busy, ifb.done, ifb.pass, ifb.in1, ifb.in0, ifb.fail_mask};
   endfunction

   task automatic set_start(input int sel, input logic v);
      if (sel == 0) ifa.start = v;
      else ifb.start = v;
   endtask

   task automatic set_gate(input int sel, input gate_e g, input int xv);
      if (sel == 0) begin gate_a = g; xvec_a = xv; end
      else begin gate_b = g; xvec_b = xv; end
   endtask

   // Edge E0: start accepted, vector 0 driven, results cleared.
   task automatic check_e0(input int sel);
      logic [8:0] o;
      o = obs(sel);
      chk("e0_busy", {3'b000, o[8]}, 4'b0001);
      chk("e0_done", {3'b000, o[7]}, 4'b0000);
      chk("e0_pass", {3'b000, o[6]}, 4'b0000);
      chk("e0_pins", {2'b00, o[5:4]}, 4'b0000);
      chk("e0_mask", o[3:0], 4'b0000);
   endtask

   task automatic start_sweep(input int sel, input bit keep, input exp_t e);
      @(negedge clk);
      set_start(sel, 1'b1);
      sb_q.push_back(e);
      @(posedge clk); #1;
      check_e0(sel);
      if (!keep) set_start(sel, 1'b0);
   endtask

   task automatic rest_sweep(input int sel);
      int s;
      logic [8:0] o;
      exp_t e;
      s = settle_of(sel);
      for (int c = 1; c < 4 * s; c++) begin
         @(posedge clk); #1;
         o = obs(sel);
         chk("run_busy", {3'b000, o[8]}, 4'b0001);
         chk("run_pins", {2'b00, o[5:4]}, 4'(c / s));
      end
      @(posedge clk); #1;
      o = obs(sel);
      chk("end_busy", {3'b000, o[8]}, 4'b0000);
      chk("end_done", {3'b000, o[7]}, 4'b0001);
      chk("end_pins", {2'b00, o[5:4]}, 4'b0000);
      if (sb_q.size() == 0) begin
         chk("sb_empty", 4'b0001, 4'b0000);
      end else begin
         e = sb_q.pop_front();
         chk("end_mask", o[3:0], e.mask);
         chk("end_pass", {3'b000, o[6]}, {3'b000, e.pass});
      end
   endtask

   initial begin
      logic [8:0] o;
      exp_t       e;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      ifa.start = 1'b0;
      ifb.start = 1'b0;
      gate_a = G_NAND; gate_b = G_NAND;
      xvec_a = -1;     xvec_b = -1;

      vecs[0] = '{sel: 0, gate: G_NAND, xvec: -1, exp_mask: 4'b0000, exp_pass: 1'b1};
      vecs[1] = '{sel: 0, gate: G_AND,  xvec: -1, exp_mask: 4'b1111, exp_pass: 1'b0};
      vecs[2] = '{sel: 0, gate: G_NAND, xvec: 1,  exp_mask: 4'b0010, exp_pass: 1'b0};
      vecs[3] = '{sel: 1, gate: G_NAND, xvec: -1, exp_mask: 4'b0000, exp_pass: 1'b1};
      vecs[4] = '{sel: 1, gate: G_AND,  xvec: -1, exp_mask: 4'b1111, exp_pass: 1'b0};
      vecs[5] = '{sel: 0, gate: G_OR,   xvec: -1, exp_mask: 4'b1001, exp_pass: 1'b0};
      vecs[6] = '{sel: 1, gate: G_XOR,  xvec: -1, exp_mask: 4'b0001, exp_pass: 1'b0};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_a", obs(0)[3:0], 4'b0000);
      chk("rst_a_ctl", {1'b0, obs(0)[8:6]}, 4'b0000);
      chk("rst_b_ctl", {1'b0, obs(1)[8:6]}, 4'b0000);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_a", {obs(0)[8:5], 1'b0} == 5'b0 ? 4'b0000 : 4'b1111, 4'b0000);

      foreach (vecs[i]) begin
         set_gate(vecs[i].sel, vecs[i].gate, vecs[i].xvec);
         e.mask = vecs[i].exp_mask;
         e.pass = vecs[i].exp_pass;
         start_sweep(vecs[i].sel, 1'b0, e);
         rest_sweep(vecs[i].sel);
      end

      // DONE must hold its results while start stays low.
      repeat (3) @(posedge clk);
      #1;
      chk("hold_done", {3'b000, ifb.done}, 4'b0001);
      chk("hold_mask", ifb.fail_mask, 4'b0001);

      // start held high: a failing sweep, then an immediate restart on the first DONE edge.
      set_gate(0, G_AND, -1);
      e.mask = 4'b1111; e.pass = 1'b0;
      start_sweep(0, 1'b1, e);
      rest_sweep(0);
      set_gate(0, G_NAND, -1);
      e.mask = 4'b0000; e.pass = 1'b1;
      sb_q.push_back(e);
      @(posedge clk); #1;
      check_e0(0);
      set_start(0, 1'b0);
      rest_sweep(0);

      // Asynchronous reset between edges while vector 2 is on the pins.
      e.mask = 4'b0000; e.pass = 1'b1;
      start_sweep(0, 1'b0, e);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_pins", {2'b00, ifa.in1, ifa.in0}, 4'b0010);
      #2;
      rst = 1'b1;
      #1;
      o = obs(0);
      chk("async_rst_pins", {2'b00, o[5:4]}, 4'b0000);
      chk("async_rst_ctl", {1'b0, o[8:6]}, 4'b0000);
      chk("async_rst_mask", o[3:0], 4'b0000);
      void'(sb_q.pop_front());
      @(negedge clk);
      rst = 1'b0;
      start_sweep(0, 1'b0, e);
      rest_sweep(0);

      chk("sb_drained", 4'(sb_q.size()), 4'b0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
